multi_zone_fan_controller: RTL and testbench

Parametrised successor to the single-pair fan controller. It samples `NUM_SENSORS` signed temperature channels once per second and keeps a per-channel moving average over a power-of-two window. From the hottest channel average it derives a 4-level fan command with hysteresis, plus a cooler enable. It sits between the sensor front-end and the fan/cooler drivers, and adds manual override and sensor-fault fail-safe.

---
 rtl/multi_zone_fan_controller.sv | 214 +++++++++++++++++++++
 tb/tb_multi_zone_fan_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_zone_fan_controller.sv
// multi_zone_fan_controller
// Samples NUM_SENSORS signed temperature channels once per tick, keeps a
// moving average per channel and turns the hottest average into a 4-level
// fan command with hysteresis, plus a cooler enable, a manual override and a
// fail-safe level when no channel reports valid data.
// All outputs are loaded on the edge that enters UPDATE, so they and the
// sample_done pulse are visible together for the whole UPDATE cycle.
module multi_zone_fan_controller #(
  parameter int CLOCK_FREQUENCY = 10000,
  parameter int NUM_SENSORS     = 4,
  parameter int TEMP_WIDTH      = 8,
  parameter int AVG_LOG2        = 3,
  parameter int LEVEL_STEP      = 4,
  parameter int HYSTERESIS      = 2,
  localparam int SEL_W          = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic signed [TEMP_WIDTH-1:0]      i_set_point,
  input  logic [NUM_SENSORS*TEMP_WIDTH-1:0] i_sensor_temps,
  input  logic [NUM_SENSORS-1:0]            i_sensor_valid,
  input  logic                              i_manual_enable,
  input  logic [1:0]                        i_manual_level,
  input  logic [SEL_W-1:0]                  i_monitor_sel,
  output logic [1:0]                        o_fan_status,
  output logic                              o_cooler_status,
  output logic [TEMP_WIDTH-1:0]             o_user_output,
  output logic                              o_sensor_fault,
  output logic                              o_sample_done
);

  localparam int CNT_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_WIDTH + AVG_LOG2;
  localparam int LVL_W = TEMP_WIDTH + 2;

  localparam logic [CNT_W-1:0]        TICK_LAST = CNT_W'(CLOCK_FREQUENCY - 1);
  localparam logic [SEL_W-1:0]        LAST_CHAN = SEL_W'(NUM_SENSORS - 1);
  localparam logic signed [LVL_W-1:0] LVL_ZERO  = '0;
  localparam logic signed [LVL_W-1:0] LVL_STEP1 = LVL_W'(LEVEL_STEP);
  localparam logic signed [LVL_W-1:0] LVL_STEP2 = LVL_W'(2 * LEVEL_STEP);
  localparam logic signed [LVL_W-1:0] LVL_HYST  = LVL_W'(HYSTERESIS);

  typedef enum logic [1:0] {IDLE, SAMPLE, EVAL, UPDATE} FsmState;

  FsmState                          r_state;
  FsmState                          w_nextState;
  logic                             w_snapshot;
  logic                             w_sampleEn;
  logic                             w_evalEn;

  logic [CNT_W-1:0]                 r_tickCnt;
  logic                             w_tick;
  logic [SEL_W-1:0]                 r_chanIdx;

  logic [NUM_SENSORS*TEMP_WIDTH-1:0] r_snapTemps;
  logic [NUM_SENSORS-1:0]           r_snapValid;
  logic signed [TEMP_WIDTH-1:0]     r_snapSetPoint;

  logic signed [TEMP_WIDTH-1:0]     r_buf [NUM_SENSORS][DEPTH];
  logic [PTR_W-1:0]                 r_ptr [NUM_SENSORS];
  logic signed [SUM_W-1:0]          r_sum [NUM_SENSORS];
  logic signed [SUM_W-1:0]          w_newExt [NUM_SENSORS];
  logic signed [SUM_W-1:0]          w_oldExt [NUM_SENSORS];
  logic signed [TEMP_WIDTH-1:0]     w_avg [NUM_SENSORS];

  logic [1:0]                       r_autoLevel;
  logic                             w_anyValid;
  logic                             w_fault;
  logic signed [TEMP_WIDTH-1:0]     w_maxAvg;
  logic [TEMP_WIDTH-1:0]            w_monitorAvg;
  logic signed [TEMP_WIDTH:0]       w_diff;
  logic signed [LVL_W-1:0]          w_diffHyst;
  logic [1:0]                       w_lvlDiff;
  logic [1:0]                       w_lvlHyst;
  logic [1:0]                       w_newLevel;

  function automatic logic [1:0] levelOf(input logic signed [LVL_W-1:0] d);
    if (d <= LVL_ZERO)       levelOf = 2'd0;
    else if (d <= LVL_STEP1) levelOf = 2'd1;
    else if (d <= LVL_STEP2) levelOf = 2'd2;
    else                     levelOf = 2'd3;
  endfunction

  assign w_tick = (r_tickCnt == TICK_LAST);

  // Free-running tick counter so the sample period stays exact regardless of FSM activity
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_tickCnt <= '0;
    else if (w_tick) r_tickCnt <= '0;
    else             r_tickCnt <= r_tickCnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // FSM next state and per-phase strobes
  always_comb begin
    w_nextState = r_state;
    w_snapshot  = 1'b0;
    w_sampleEn  = 1'b0;
    w_evalEn    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_snapshot  = 1'b1;
          w_nextState = SAMPLE;
        end
      end
      SAMPLE: begin
        w_sampleEn = 1'b1;
        if (r_chanIdx == LAST_CHAN) w_nextState = EVAL;
      end
      EVAL: begin
        w_evalEn    = 1'b1;
        w_nextState = UPDATE;
      end
      UPDATE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Freeze the inputs at the tick and step through the channels one per SAMPLE cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_snapTemps    <= '0;
      r_snapValid    <= '0;
      r_snapSetPoint <= '0;
      r_chanIdx      <= '0;
    end else if (w_snapshot) begin
      r_snapTemps    <= i_sensor_temps;
      r_snapValid    <= i_sensor_valid;
      r_snapSetPoint <= i_set_point;
      r_chanIdx      <= '0;
    end else if (w_sampleEn) begin
      r_chanIdx      <= r_chanIdx + 1'b1;
    end
  end

  // Sign-extended new/oldest samples and the floor-rounded average of every channel
  always_comb begin
    for (int k = 0; k < NUM_SENSORS; k++) begin
      w_newExt[k] = SUM_W'($signed(r_snapTemps[k*TEMP_WIDTH +: TEMP_WIDTH]));
      w_oldExt[k] = SUM_W'(r_buf[k][r_ptr[k]]);
      w_avg[k]    = TEMP_WIDTH'(r_sum[k] >>> AVG_LOG2);
    end
  end

  // Circular buffers and running sums; an invalid channel leaves its history untouched
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        r_ptr[k] <= '0;
        r_sum[k] <= '0;
        for (int d = 0; d < DEPTH; d++) r_buf[k][d] <= '0;
      end
    end else if (w_sampleEn) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        if (r_chanIdx == SEL_W'(k) && r_snapValid[k]) begin
          r_buf[k][r_ptr[k]] <= r_snapTemps[k*TEMP_WIDTH +: TEMP_WIDTH];
          r_sum[k]           <= r_sum[k] + w_newExt[k] - w_oldExt[k];
          r_ptr[k]           <= r_ptr[k] + 1'b1;
        end
      end
    end
  end

  // Hottest valid average, error against set point and the monitored channel
  always_comb begin
    w_anyValid   = 1'b0;
    w_maxAvg     = '0;
    w_monitorAvg = w_avg[0];
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (r_snapValid[k] && (!w_anyValid || w_avg[k] > w_maxAvg)) begin
        w_maxAvg   = w_avg[k];
        w_anyValid = 1'b1;
      end
      if (i_monitor_sel == SEL_W'(k)) w_monitorAvg = w_avg[k];
    end
    w_diff     = {w_maxAvg[TEMP_WIDTH-1], w_maxAvg} - {r_snapSetPoint[TEMP_WIDTH-1], r_snapSetPoint};
    w_diffHyst = {w_diff[TEMP_WIDTH], w_diff} + LVL_HYST;
  end

  assign w_fault    = ~w_anyValid;
  assign w_lvlDiff  = levelOf({w_diff[TEMP_WIDTH], w_diff});
  assign w_lvlHyst  = levelOf(w_diffHyst);
  assign w_newLevel = w_fault ? 2'd3 : ((w_lvlDiff >= r_autoLevel) ? w_lvlDiff : w_lvlHyst);

  // Commit the new automatic level and all outputs on entry to UPDATE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_autoLevel     <= '0;
      o_fan_status    <= '0;
      o_cooler_status <= 1'b0;
      o_user_output   <= '0;
      o_sensor_fault  <= 1'b0;
      o_sample_done   <= 1'b0;
    end else begin
      o_sample_done <= w_evalEn;
      if (w_evalEn) begin
        r_autoLevel     <= w_newLevel;
        o_fan_status    <= i_manual_enable ? i_manual_level : w_newLevel;
        o_cooler_status <= (w_newLevel >= 2'd2) | w_fault;
        o_user_output   <= w_monitorAvg;
        o_sensor_fault  <= w_fault;
      end
    end
  end

endmodule

// File: tb/tb_multi_zone_fan_controller.sv
// tb_multi_zone_fan_controller
// Directed scenarios plus random ticks, each compared with a queue-based
// reference model of the averaging, hysteresis and fail-safe rules.
`timescale 1ns/1ps
module tb_multi_zone_fan_controller;

  localparam int CF  = 10;
  localparam int NS  = 4;
  localparam int TW  = 8;
  localparam int AL  = 2;
  localparam int LS  = 4;
  localparam int HY  = 2;
  localparam int WIN = 1 << AL;

  logic            clk = 1'b0;
  logic            reset;
  logic [TW-1:0]   setPoint;
  logic [NS*TW-1:0] sensorTemps;
  logic [NS-1:0]   sensorValid;
  logic            manualEnable;
  logic [1:0]      manualLevel;
  logic [1:0]      monitorSel;
  logic [1:0]      fanStatus;
  logic            coolerStatus;
  logic [TW-1:0]   userOutput;
  logic            sensorFault;
  logic            sampleDone;

  int checks = 0;
  int errors = 0;

  int hist [NS][$];
  int modelAuto;
  int expFan, expCooler, expUser, expFault;

  always #5 clk = ~clk;

  multi_zone_fan_controller #(
    .CLOCK_FREQUENCY(CF), .NUM_SENSORS(NS), .TEMP_WIDTH(TW),
    .AVG_LOG2(AL), .LEVEL_STEP(LS), .HYSTERESIS(HY)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_set_point(setPoint),
    .i_sensor_temps(sensorTemps), .i_sensor_valid(sensorValid),
    .i_manual_enable(manualEnable), .i_manual_level(manualLevel),
    .i_monitor_sel(monitorSel), .o_fan_status(fanStatus),
    .o_cooler_status(coolerStatus), .o_user_output(userOutput),
    .o_sensor_fault(sensorFault), .o_sample_done(sampleDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floorDiv(input int s, input int w);
    if (s >= 0) return s / w;
    return -((-s + w - 1) / w);
  endfunction

  function automatic int lvlOf(input int d);
    if (d <= 0)      return 0;
    if (d <= LS)     return 1;
    if (d <= 2 * LS) return 2;
    return 3;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NS; k++) begin
      hist[k] = {};
      for (int i = 0; i < WIN; i++) hist[k].push_back(0);
    end
    modelAuto = 0;
  endtask

  task automatic modelTick(input int t[NS], input logic [NS-1:0] v, input int sp,
                           input logic me, input logic [1:0] ml, input int sel);
    int avg[NS];
    bit any;
    int maxAvg;
    int sum;
    int d;
    any = 0;
    maxAvg = 0;
    for (int k = 0; k < NS; k++) begin
      if (v[k]) begin
        hist[k].push_back(t[k]);
        void'(hist[k].pop_front());
      end
      sum = 0;
      for (int i = 0; i < hist[k].size(); i++) sum += hist[k][i];
      avg[k] = floorDiv(sum, WIN);
    end
    for (int k = 0; k < NS; k++) begin
      if (v[k]) begin
        if (!any || avg[k] > maxAvg) maxAvg = avg[k];
        any = 1;
      end
    end
    if (!any) begin
      expFault  = 1;
      modelAuto = 3;
    end else begin
      expFault = 0;
      d = maxAvg - sp;
      if (lvlOf(d) >= modelAuto) modelAuto = lvlOf(d);
      else                       modelAuto = lvlOf(d + HY);
    end
    expFan    = me ? int'(ml) : modelAuto;
    expCooler = (modelAuto >= 2 || expFault == 1) ? 1 : 0;
    expUser   = ((sel < NS) ? avg[sel] : avg[0]) & 32'hFF;
  endtask

  task automatic driveInputs(input int t[NS], input logic [NS-1:0] v, input int sp,
                             input logic me, input logic [1:0] ml, input int sel);
    for (int k = 0; k < NS; k++) sensorTemps[k*TW +: TW] = t[k][TW-1:0];
    sensorValid  = v;
    setPoint     = sp[TW-1:0];
    manualEnable = me;
    manualLevel  = ml;
    monitorSel   = sel[1:0];
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_fan"},    32'(fanStatus),    expFan);
    check({tag, "_cooler"}, 32'(coolerStatus), expCooler);
    check({tag, "_user"},   32'(userOutput),   expUser);
    check({tag, "_fault"},  32'(sensorFault),  expFault);
  endtask

  task automatic finishRound(input string tag);
    checkOutput(tag);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(sampleDone), 0);
  endtask

  task automatic applyStimulus(input int t[NS], input logic [NS-1:0] v, input int sp,
                               input logic me, input logic [1:0] ml, input int sel,
                               input string tag);
    int n;
    driveInputs(t, v, sp, me, ml, sel);
    modelTick(t, v, sp, me, ml, sel);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sampleDone !== 1'b1 && n < 3 * CF);
    check({tag, "_period"}, n, CF - 1);
    finishRound(tag);
  endtask

  task automatic applyFirst(input int t[NS], input logic [NS-1:0] v, input int sp,
                            input logic me, input logic [1:0] ml, input int sel,
                            input string tag);
    int n;
    bit quiet;
    driveInputs(t, v, sp, me, ml, sel);
    modelReset();
    modelTick(t, v, sp, me, ml, sel);
    reset = 1'b0;
    n = 0;
    quiet = 1;
    do begin
      @(negedge clk);
      n++;
      if (sampleDone !== 1'b1 &&
          (fanStatus !== 2'd0 || coolerStatus !== 1'b0 || userOutput !== '0 || sensorFault !== 1'b0))
        quiet = 0;
    end while (sampleDone !== 1'b1 && n < 3 * CF);
    check({tag, "_latency"}, n, CF - 1 + NS + 2);
    check({tag, "_heldZero"}, 32'(quiet), 1);
    finishRound(tag);
  endtask

  initial begin
    int t[NS];
    logic [NS-1:0] v;
    bit quiet;

    reset = 1'b1;
    driveInputs('{0, 0, 0, 0}, '0, 0, 1'b0, 2'd0, 0);
    repeat (3) @(negedge clk);
    check("rst_fan",    32'(fanStatus),    0);
    check("rst_cooler", 32'(coolerStatus), 0);
    check("rst_user",   32'(userOutput),   0);
    check("rst_fault",  32'(sensorFault),  0);
    check("rst_done",   32'(sampleDone),   0);

    $display("[TB] ramp at 30");
    applyFirst('{30, 30, 30, 30}, 4'b1111, 20, 1'b0, 2'd0, 0, "ramp1");
    check("ramp1_avgLit", 32'(userOutput), 7);
    applyStimulus('{30, 30, 30, 30}, 4'b1111, 20, 1'b0, 2'd0, 0, "ramp2");
    check("ramp2_avgLit", 32'(userOutput), 15);
    applyStimulus('{30, 30, 30, 30}, 4'b1111, 20, 1'b0, 2'd0, 0, "ramp3");
    check("ramp3_avgLit", 32'(userOutput), 22);
    check("ramp3_fanLit", 32'(fanStatus), 1);
    applyStimulus('{30, 30, 30, 30}, 4'b1111, 20, 1'b0, 2'd0, 0, "ramp4");
    check("ramp4_fanLit", 32'(fanStatus), 3);
    check("ramp4_coolLit", 32'(coolerStatus), 1);

    $display("[TB] hysteresis descent");
    repeat (4) applyStimulus('{29, 29, 29, 29}, 4'b1111, 20, 1'b0, 2'd0, 0, "hyst29");
    repeat (4) applyStimulus('{28, 28, 28, 28}, 4'b1111, 20, 1'b0, 2'd0, 0, "hyst28");
    check("hyst28_fanLit", 32'(fanStatus), 3);
    repeat (4) applyStimulus('{26, 26, 26, 26}, 4'b1111, 20, 1'b0, 2'd0, 0, "hyst26");
    check("hyst26_fanLit", 32'(fanStatus), 2);

    $display("[TB] sensor fault");
    applyStimulus('{100, 100, 100, 100}, 4'b0000, 20, 1'b0, 2'd0, 0, "fault");
    check("fault_flagLit", 32'(sensorFault), 1);
    check("fault_fanLit", 32'(fanStatus), 3);
    check("fault_userLit", 32'(userOutput), 26);
    applyStimulus('{26, 0, 0, 0}, 4'b0001, 20, 1'b0, 2'd0, 0, "recover");
    check("recover_flagLit", 32'(sensorFault), 0);

    $display("[TB] manual override");
    repeat (4) applyStimulus('{40, 40, 40, 40}, 4'b1111, 20, 1'b1, 2'd1, 0, "manual");
    check("manual_fanLit", 32'(fanStatus), 1);
    check("manual_coolLit", 32'(coolerStatus), 1);
    applyStimulus('{40, 40, 40, 40}, 4'b1111, 20, 1'b0, 2'd1, 0, "auto");
    check("auto_fanLit", 32'(fanStatus), 3);

    $display("[TB] negative channel monitor");
    repeat (4) applyStimulus('{20, 20, -8, 20}, 4'b1111, 20, 1'b0, 2'd0, 2, "neg");
    check("neg_userLit", 32'(userOutput), 32'hF8);

    $display("[TB] random ticks");
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < NS; k++) t[k] = int'($urandom_range(120)) - 60;
      v = NS'($urandom_range(15));
      if (r % 6 == 5) v = '0;
      applyStimulus(t, v, int'($urandom_range(60)) - 30, 1'($urandom_range(1)),
                    2'($urandom_range(3)), int'($urandom_range(NS - 1)), "rand");
    end

    $display("[TB] reset during sampling");
    driveInputs('{50, 50, 50, 50}, 4'b1111, 20, 1'b0, 2'd0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    quiet = 1;
    repeat (8) begin
      @(negedge clk);
      if (sampleDone !== 1'b0 || fanStatus !== 2'd0 || coolerStatus !== 1'b0 ||
          userOutput !== '0 || sensorFault !== 1'b0)
        quiet = 0;
    end
    check("abort_quiet", 32'(quiet), 1);
    applyFirst('{12, 12, 12, 12}, 4'b1111, 20, 1'b0, 2'd0, 0, "post1");
    check("post1_userLit", 32'(userOutput), 3);
    applyStimulus('{12, 12, 12, 12}, 4'b1111, 20, 1'b0, 2'd0, 0, "post2");
    applyStimulus('{12, 12, 12, 12}, 4'b1111, 0, 1'b0, 2'd0, 1, "post3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
